// File: rtl/m_instruction_fetch_unit.sv
// Instruction fetch unit: IDLE/FETCH/ISSUE/HALT sequencer driving imem and decoder.
// Optional macro FETCH_HALT_DETECT_EN: an issued 8'h00 parks the unit in HALT.
module m_instruction_fetch_unit #(
   parameter int                    P_PC_WIDTH = 8,
   parameter logic [P_PC_WIDTH-1:0] P_RESET_PC = '0
) (
   input  logic                  w_clock,
   input  logic                  w_reset_n,
   output logic                  w_imem_req,
   output logic [P_PC_WIDTH-1:0] w_imem_addr,
   input  logic [7:0]            w_imem_data,
   input  logic                  w_imem_valid,
   output logic [7:0]            w_bus_wordout,
   output logic                  w_instr_valid,
   input  logic                  w_jump_flag,
   input  logic [P_PC_WIDTH-1:0] w_jump_target,
   input  logic                  w_stall,
   output logic [P_PC_WIDTH-1:0] w_link_pc,
   output logic                  w_halted
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_HALT
   } state_t;

   localparam logic [P_PC_WIDTH-1:0] PC_ONE = 1;

   state_t                  state_q;
   logic [P_PC_WIDTH-1:0]   pc_q;
   logic [7:0]              word_q;
   logic                    req_q;
   logic                    ivalid_q;
   logic                    halt_hit;

`ifdef FETCH_HALT_DETECT_EN
   assign halt_hit = (word_q == 8'h00);
   assign w_halted = (state_q == S_HALT);
`else
   assign halt_hit = 1'b0;
   assign w_halted = 1'b0;
`endif

   assign w_imem_req    = req_q;
   assign w_imem_addr   = pc_q;
   assign w_bus_wordout = word_q;
   assign w_instr_valid = ivalid_q;
   assign w_link_pc     = pc_q + PC_ONE;

   always_ff @(posedge w_clock or negedge w_reset_n) begin
      if (!w_reset_n) begin
         state_q  <= S_IDLE;
         pc_q     <= P_RESET_PC;
         word_q   <= 8'h00;
         req_q    <= 1'b0;
         ivalid_q <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               state_q <= S_FETCH;
               req_q   <= 1'b1;
            end
            S_FETCH: begin
               if (w_imem_valid) begin
                  word_q   <= w_imem_data;
                  state_q  <= S_ISSUE;
                  req_q    <= 1'b0;
                  ivalid_q <= 1'b1;
               end
            end
            S_ISSUE: begin
               // A stall freezes everything, including jump handling.
               if (!w_stall) begin
                  ivalid_q <= 1'b0;
                  if (halt_hit) begin
                     state_q <= S_HALT;
                  end else begin
                     state_q <= S_FETCH;
                     req_q   <= 1'b1;
                     pc_q    <= w_jump_flag ? w_jump_target
                                            : pc_q + PC_ONE;
                  end
               end
            end
            S_HALT: begin
               state_q <= S_HALT;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule
